// File: rtl/mc_mem_responder.sv
// Word-addressed memory responder: valid/ready request, fixed-latency one-cycle response pulse.
// Optional feature: define MC_MEM_RESPONDER_MISALIGN_CHECK_EN to fault addresses with req_addr[1:0] != 0.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the array (power of two, 16..65536)
//   WAIT_CYCLES  wait states between request acceptance and response (0..255)
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready           request handshake; ready only while idle
//   req_write                     1 = store, 0 = load
//   req_addr, req_wdata, req_be   byte address, store data, byte enables
//   rsp_valid                     one-cycle response pulse, no backpressure
//   rsp_rdata, rsp_err            load data and fault flag, zero outside the pulse
module mc_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [7:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

`ifdef MC_MEM_RESPONDER_MISALIGN_CHECK_EN
    localparam logic MISALIGN_CHK = 1'b1;
`else
    localparam logic MISALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        accept;
    logic        access;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic [AW-1:0] idx;
    logic        oob;
    logic        misal;
    logic        err;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = S_RESP;
                        access   = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 8'd0) begin
                    state_nx = S_RESP;
                    access   = 1'b1;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge,
    // so the live request is used instead of the latched copy.
    assign a_write = (state == S_IDLE) ? req_write : lat_write;
    assign a_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign a_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
    assign a_be    = (state == S_IDLE) ? req_be    : lat_be;

    assign idx   = a_addr[AW+1:2];
    assign oob   = |a_addr[31:AW+2];
    assign misal = |a_addr[1:0];
    assign err   = oob | (MISALIGN_CHK & misal);

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            // Response registers are only non-zero for the single RESP cycle.
            if (access) begin
                rsp_err   <= err;
                rsp_rdata <= (a_write || err) ? 32'd0 : mem[idx];
            end else begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Array is not reset; the rst gate keeps a store from committing
    // on an edge where reset is held.
    always_ff @(posedge clk) begin
        if (access && !rst && a_write && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) begin
                    mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench for mc_mem_responder: scoreboard queues, directed steps.
// u0 uses WAIT_CYCLES=2, u1 uses WAIT_CYCLES=0 for back-to-back streaming.
module tb_mc_mem_responder;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v0 = 0, w0 = 0;
    logic [31:0] a0 = 0, d0 = 0;
    logic [3:0]  b0 = 0;
    logic        rdy0, rv0, re0;
    logic [31:0] rd0;

    logic        v1 = 0, w1 = 0;
    logic [31:0] a1 = 0, d1 = 0;
    logic [3:0]  b1 = 0;
    logic        rdy1, rv1, re1;
    logic [31:0] rd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp1_n = 0;
    exp_t q0[$];
    exp_t q1[$];

    mc_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_write(w0), .req_addr(a0),
        .req_wdata(d0), .req_be(b0), .req_ready(rdy0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
    );

    mc_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_write(w1), .req_addr(a1),
        .req_wdata(d1), .req_be(b1), .req_ready(rdy1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rv0) begin
                chk("u0_rsp_expected", q0.size() != 0, 1);
                if (q0.size() != 0) begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("u0_rdata", rd0, e.d);
                    chk("u0_err", re0, e.e);
                    chk("u0_latency", cyc - e.c, 3);
                end
            end else begin
                chk("u0_idle_rdata", rd0, 0);
                chk("u0_idle_err", re0, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rv1) begin
            rsp1_n++;
            chk("u1_rsp_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("u1_rdata", rd1, e.d);
                chk("u1_err", re1, e.e);
                chk("u1_latency", cyc - e.c, 1);
            end
        end
    end

    task automatic issue0(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] ed, input logic ee,
                          input logic push);
        int n;
        n = 0;
        @(negedge clk);
        v0 = 1; w0 = w; a0 = a; d0 = d; b0 = be;
        while (!rdy0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("u0_ready_wait", rdy0, 1);
        if (push) q0.push_back('{ed, ee, cyc});
        @(negedge clk);
        v0 = 0;
        chk("u0_busy_ready", rdy0, 0);
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (q0.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("u0_drain", q0.size(), 0);
    endtask

    task automatic drain1();
        int n;
        n = 0;
        while (q1.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("u1_drain", q1.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rv0, 0);
        chk("rst_rdata", rd0, 0);
        chk("rst_err", re0, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", rdy0, 1);

        issue0(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1);
        drain0();
        issue0(0, 32'h10, 0, 4'hF, 32'hDEADBEEF, 0, 1);
        drain0();

        issue0(1, 32'h20, 32'h11223344, 4'hF, 0, 0, 1);
        issue0(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 1);
        issue0(0, 32'h20, 0, 4'hF, 32'h11BB33DD, 0, 1);
        issue0(1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, 1);
        issue0(0, 32'h20, 0, 4'hF, 32'h11BB33DD, 0, 1);
        issue0(0, 32'h10, 0, 4'h0, 32'hDEADBEEF, 0, 1);
        drain0();

        issue0(1, 32'h0, 32'h0BADF00D, 4'hF, 0, 0, 1);
        issue0(0, 32'h1000, 0, 4'hF, 0, 1, 1);
        issue0(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 1, 1);
        issue0(0, 32'h0, 0, 4'hF, 32'h0BADF00D, 0, 1);
        issue0(1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 0, 0, 1);
        issue0(0, 32'hFFC, 0, 4'hF, 32'h5A5A5A5A, 0, 1);
        issue0(0, 32'hFFFFFFFC, 0, 4'hF, 0, 1, 1);
        issue0(1, 32'h40, 32'h12345678, 4'hF, 0, 0, 1);
        drain0();

        issue0(1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("abort_rsp_valid", rv0, 0);
        chk("abort_rdata", rd0, 0);
        @(negedge clk);
        rst = 0;
        repeat (6) @(negedge clk);
        chk("abort_ready", rdy0, 1);
        chk("abort_queue", q0.size(), 0);
        issue0(0, 32'h40, 0, 4'hF, 32'h12345678, 0, 1);
`ifdef MC_MEM_RESPONDER_MISALIGN_CHECK_EN
        issue0(0, 32'h42, 0, 4'hF, 0, 1, 1);
`else
        issue0(0, 32'h42, 0, 4'hF, 32'h12345678, 0, 1);
`endif
        drain0();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v1 = 1; w1 = 1; b1 = 4'hF;
            a1 = 32'(i * 4);
            d1 = 32'hA0000000 + 32'(i);
            chk("u1_alt_ready", rdy1, (i % 2) == 0);
            if (rdy1) q1.push_back('{32'd0, 1'b0, cyc});
        end
        @(negedge clk);
        v1 = 0;
        drain1();
        chk("u1_rsp_count", rsp1_n, 5);
        @(negedge clk);
        v1 = 1; w1 = 0; a1 = 32'd16;
        chk("u1_load_ready", rdy1, 1);
        q1.push_back('{32'hA0000004, 1'b0, cyc});
        @(negedge clk);
        v1 = 0;
        drain1();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
